// File: rtl/bp_cce_lce_req_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bp_cce_lce_req_responder
//  Purpose  : CCE-side responder for LCE miss requests. Accepts one miss
//             request, reads the block from memory, sends a data command and
//             then a set-tag command to the requesting LCE, and waits for the
//             matching coherence ack before accepting another request.
//             Only one transaction is outstanding at a time.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk_i, reset_i                 clock, asynchronous active-high reset
//    lce_req_i/_v_i/_ready_o        LCE request (ready/valid)
//    mem_cmd_addr_o/_v_o/_ready_i   memory block read command (ready/valid)
//    mem_data_i/_v_i/_yumi_o        memory block return (valid/yumi)
//    lce_data_cmd_*                 data command to the requesting LCE
//    lce_cmd_*                      set-tag command to the requesting LCE
//    lce_resp_i/_v_i/_yumi_o        LCE response (coherence ack)
//    busy_o                         a transaction is in flight
//    bad_resp_o                     a non-matching response is being dropped
// ============================================================================
module bp_cce_lce_req_responder #(
    parameter int NUM_LCE_P          = 2,
    parameter int PADDR_WIDTH_P      = 22,
    parameter int WAYS_P             = 8,
    parameter int BLOCK_DATA_WIDTH_P = 512,
    localparam int LCE_ID_W          = $clog2(NUM_LCE_P),
    localparam int WAY_W             = $clog2(WAYS_P)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic [96:0]                   lce_req_i,
    input  logic                          lce_req_v_i,
    output logic                          lce_req_ready_o,

    output logic [PADDR_WIDTH_P-1:0]      mem_cmd_addr_o,
    output logic                          mem_cmd_v_o,
    input  logic                          mem_cmd_ready_i,

    input  logic [BLOCK_DATA_WIDTH_P-1:0] mem_data_i,
    input  logic                          mem_data_v_i,
    output logic                          mem_data_yumi_o,

    output logic [LCE_ID_W-1:0]           lce_data_cmd_dst_o,
    output logic [WAY_W-1:0]              lce_data_cmd_way_o,
    output logic [PADDR_WIDTH_P-1:0]      lce_data_cmd_addr_o,
    output logic [BLOCK_DATA_WIDTH_P-1:0] lce_data_cmd_data_o,
    output logic                          lce_data_cmd_v_o,
    input  logic                          lce_data_cmd_ready_i,

    output logic [LCE_ID_W-1:0]           lce_cmd_dst_o,
    output logic [WAY_W-1:0]              lce_cmd_way_o,
    output logic [PADDR_WIDTH_P-1:0]      lce_cmd_addr_o,
    output logic [1:0]                    lce_cmd_state_o,
    output logic                          lce_cmd_type_o,
    output logic                          lce_cmd_v_o,
    input  logic                          lce_cmd_ready_i,

    input  logic [25:0]                   lce_resp_i,
    input  logic                          lce_resp_v_i,
    output logic                          lce_resp_yumi_o,

    output logic                          busy_o,
    output logic                          bad_resp_o
);

    // Request / response field positions
    localparam int REQ_ID_MSB   = 31;
    localparam int REQ_MISS_BIT = 29;
    localparam int REQ_ADDR_LSB = 7;
    localparam int REQ_WAY_LSB  = 4;
    localparam int REQ_NX_BIT   = 32;
    localparam int RSP_ID_MSB   = 24;
    localparam int RSP_ADDR_LSB = 0;

    localparam logic [1:0] COH_ACK   = 2'b11;
    localparam logic [1:0] COH_ST_S  = 2'b01;
    localparam logic [1:0] COH_ST_E  = 2'b10;

    typedef enum logic [2:0] {
        ST_READY     = 3'd0,
        ST_MEM_REQ   = 3'd1,
        ST_MEM_WAIT  = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_SEND_TAG  = 3'd4,
        ST_WAIT_ACK  = 3'd5
    } state_e;

    state_e                          state_q, state_d;
    logic [LCE_ID_W-1:0]             id_q, id_d;
    logic [PADDR_WIDTH_P-1:0]        addr_q, addr_d;
    logic [WAY_W-1:0]                way_q, way_d;
    logic                            nx_q, nx_d;
    logic [BLOCK_DATA_WIDTH_P-1:0]   data_q, data_d;

    logic w_ack_match;
    logic w_unused;

    // Only the listed fields of the request/response buses carry meaning.
    assign w_unused = ^{lce_req_i, lce_resp_i};

    assign w_ack_match = (lce_resp_i[23:22] == COH_ACK)
                      && (lce_resp_i[RSP_ID_MSB -: LCE_ID_W] == id_q)
                      && (lce_resp_i[RSP_ADDR_LSB +: PADDR_WIDTH_P] == addr_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        way_d   = way_q;
        nx_d    = nx_q;
        data_d  = data_q;
        case (state_q)
            ST_READY: begin
                // Non-miss requests are consumed (ready is high) but ignored.
                if (lce_req_v_i && lce_req_i[REQ_MISS_BIT]) begin
                    id_d    = lce_req_i[REQ_ID_MSB -: LCE_ID_W];
                    addr_d  = lce_req_i[REQ_ADDR_LSB +: PADDR_WIDTH_P];
                    way_d   = lce_req_i[REQ_WAY_LSB +: WAY_W];
                    nx_d    = lce_req_i[REQ_NX_BIT];
                    state_d = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                if (mem_cmd_ready_i) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_data_v_i) begin
                    data_d  = mem_data_i;
                    state_d = ST_SEND_DATA;
                end
            end
            ST_SEND_DATA: begin
                if (lce_data_cmd_ready_i) begin
                    state_d = ST_SEND_TAG;
                end
            end
            ST_SEND_TAG: begin
                if (lce_cmd_ready_i) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // Mismatched responses are consumed and dropped in place.
                if (lce_resp_v_i && w_ack_match) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_READY;
            id_q    <= '0;
            addr_q  <= '0;
            way_q   <= '0;
            nx_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            way_q   <= way_d;
            nx_q    <= nx_d;
            data_q  <= data_d;
        end
    end

    // Valids decode the registered state, so payloads (held in the latched
    // registers) stay stable until the corresponding handshake completes.
    assign lce_req_ready_o     = (state_q == ST_READY) && !reset_i;

    assign mem_cmd_addr_o      = addr_q;
    assign mem_cmd_v_o         = (state_q == ST_MEM_REQ);
    assign mem_data_yumi_o     = (state_q == ST_MEM_WAIT) && mem_data_v_i;

    assign lce_data_cmd_dst_o  = id_q;
    assign lce_data_cmd_way_o  = way_q;
    assign lce_data_cmd_addr_o = addr_q;
    assign lce_data_cmd_data_o = data_q;
    assign lce_data_cmd_v_o    = (state_q == ST_SEND_DATA);

    assign lce_cmd_dst_o       = id_q;
    assign lce_cmd_way_o       = way_q;
    assign lce_cmd_addr_o      = addr_q;
    assign lce_cmd_state_o     = nx_q ? COH_ST_S : COH_ST_E;
    assign lce_cmd_type_o      = 1'b0;
    assign lce_cmd_v_o         = (state_q == ST_SEND_TAG);

    assign lce_resp_yumi_o     = (state_q == ST_WAIT_ACK) && lce_resp_v_i;
    assign bad_resp_o          = (state_q == ST_WAIT_ACK) && lce_resp_v_i && !w_ack_match;

    assign busy_o              = (state_q != ST_READY);

endmodule
`default_nettype wire

// File: tb/tb_bp_cce_lce_req_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bp_cce_lce_req_responder
//  Purpose  : Scoreboard bench for bp_cce_lce_req_responder. Stimulus pushes
//             the expected memory command, data command, set-tag command and
//             ack outcome into queues; a monitor pops and compares whenever
//             the DUT presents a handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_cce_lce_req_responder;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [96:0]  lce_req_i;
    logic         lce_req_v_i;
    logic         lce_req_ready_o;
    logic [21:0]  mem_cmd_addr_o;
    logic         mem_cmd_v_o;
    logic         mem_cmd_ready_i;
    logic [511:0] mem_data_i;
    logic         mem_data_v_i;
    logic         mem_data_yumi_o;
    logic         lce_data_cmd_dst_o;
    logic [2:0]   lce_data_cmd_way_o;
    logic [21:0]  lce_data_cmd_addr_o;
    logic [511:0] lce_data_cmd_data_o;
    logic         lce_data_cmd_v_o;
    logic         lce_data_cmd_ready_i;
    logic         lce_cmd_dst_o;
    logic [2:0]   lce_cmd_way_o;
    logic [21:0]  lce_cmd_addr_o;
    logic [1:0]   lce_cmd_state_o;
    logic         lce_cmd_type_o;
    logic         lce_cmd_v_o;
    logic         lce_cmd_ready_i;
    logic [25:0]  lce_resp_i;
    logic         lce_resp_v_i;
    logic         lce_resp_yumi_o;
    logic         busy_o;
    logic         bad_resp_o;

    bp_cce_lce_req_responder dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i), .lce_req_ready_o(lce_req_ready_o),
        .mem_cmd_addr_o(mem_cmd_addr_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_data_i(mem_data_i), .mem_data_v_i(mem_data_v_i), .mem_data_yumi_o(mem_data_yumi_o),
        .lce_data_cmd_dst_o(lce_data_cmd_dst_o), .lce_data_cmd_way_o(lce_data_cmd_way_o),
        .lce_data_cmd_addr_o(lce_data_cmd_addr_o), .lce_data_cmd_data_o(lce_data_cmd_data_o),
        .lce_data_cmd_v_o(lce_data_cmd_v_o), .lce_data_cmd_ready_i(lce_data_cmd_ready_i),
        .lce_cmd_dst_o(lce_cmd_dst_o), .lce_cmd_way_o(lce_cmd_way_o), .lce_cmd_addr_o(lce_cmd_addr_o),
        .lce_cmd_state_o(lce_cmd_state_o), .lce_cmd_type_o(lce_cmd_type_o),
        .lce_cmd_v_o(lce_cmd_v_o), .lce_cmd_ready_i(lce_cmd_ready_i),
        .lce_resp_i(lce_resp_i), .lce_resp_v_i(lce_resp_v_i), .lce_resp_yumi_o(lce_resp_yumi_o),
        .busy_o(busy_o), .bad_resp_o(bad_resp_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         dst;
        logic [2:0]   way;
        logic [21:0]  addr;
        logic [511:0] data;
    } dcmd_t;

    typedef struct packed {
        logic        dst;
        logic [2:0]  way;
        logic [21:0] addr;
        logic [1:0]  st;
    } cmd_t;

    logic [21:0] q_mem[$];
    dcmd_t       q_dcmd[$];
    cmd_t        q_cmd[$];
    logic        q_resp[$];

    // Readiness control for the downstream sinks.
    logic rand_ready      = 1'b0;
    logic hold_dready_low = 1'b0;

    function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic void fail_now(string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endfunction

    // Memory contents: a fixed function of the block address.
    function automatic logic [511:0] memfn(logic [21:0] a);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i*32 +: 32] = {a, 10'(i)} ^ 32'h5A5A_C3C3;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Sink readiness driver
    // ------------------------------------------------------------------
    initial begin
        mem_cmd_ready_i      = 1'b1;
        lce_data_cmd_ready_i = 1'b1;
        lce_cmd_ready_i      = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            mem_cmd_ready_i      = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            lce_data_cmd_ready_i = hold_dready_low ? 1'b0 :
                                   (rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
            lce_cmd_ready_i      = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        logic          pend_m, pend_d, pend_c;
        logic [22:0]   sv_m;
        logic [538:0]  sv_d;
        logic [29:0]   sv_c;
        logic [21:0]   ea;
        dcmd_t         ed;
        cmd_t          ec;
        logic          eb;
        pend_m = 1'b0; pend_d = 1'b0; pend_c = 1'b0;
        sv_m = '0; sv_d = '0; sv_c = '0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                pend_m = 1'b0; pend_d = 1'b0; pend_c = 1'b0;
            end else begin
                // payload stability while stalled
                if (pend_m) chk("mem_cmd_hold", {mem_cmd_v_o, mem_cmd_addr_o}, sv_m);
                if (pend_d) chk("dcmd_hold", {lce_data_cmd_v_o, lce_data_cmd_dst_o, lce_data_cmd_way_o,
                                              lce_data_cmd_addr_o, lce_data_cmd_data_o}, sv_d);
                if (pend_c) chk("cmd_hold", {lce_cmd_v_o, lce_cmd_dst_o, lce_cmd_way_o,
                                             lce_cmd_addr_o, lce_cmd_state_o}, sv_c);

                if (mem_cmd_v_o && mem_cmd_ready_i) begin
                    if (q_mem.size() == 0) fail_now("mem_cmd_unexpected");
                    else begin
                        ea = q_mem.pop_front();
                        chk("mem_cmd_addr", mem_cmd_addr_o, ea);
                    end
                end
                if (lce_data_cmd_v_o && lce_data_cmd_ready_i) begin
                    if (q_dcmd.size() == 0) fail_now("dcmd_unexpected");
                    else begin
                        ed = q_dcmd.pop_front();
                        chk("dcmd_dst",  lce_data_cmd_dst_o,  ed.dst);
                        chk("dcmd_way",  lce_data_cmd_way_o,  ed.way);
                        chk("dcmd_addr", lce_data_cmd_addr_o, ed.addr);
                        chk("dcmd_data", lce_data_cmd_data_o, ed.data);
                    end
                end
                if (lce_cmd_v_o && lce_cmd_ready_i) begin
                    if (q_cmd.size() == 0) fail_now("cmd_unexpected");
                    else begin
                        ec = q_cmd.pop_front();
                        chk("cmd_dst",   lce_cmd_dst_o,   ec.dst);
                        chk("cmd_way",   lce_cmd_way_o,   ec.way);
                        chk("cmd_addr",  lce_cmd_addr_o,  ec.addr);
                        chk("cmd_state", lce_cmd_state_o, ec.st);
                        chk("cmd_type",  lce_cmd_type_o,  1'b0);
                    end
                end
                if (lce_resp_yumi_o) begin
                    if (q_resp.size() == 0) fail_now("resp_unexpected_yumi");
                    else begin
                        eb = q_resp.pop_front();
                        chk("bad_resp", bad_resp_o, eb);
                    end
                end else if (bad_resp_o) begin
                    fail_now("bad_resp_without_yumi");
                end
                if (mem_data_yumi_o && !mem_data_v_i) fail_now("mem_yumi_without_v");

                pend_m = mem_cmd_v_o && !mem_cmd_ready_i;
                sv_m   = {mem_cmd_v_o, mem_cmd_addr_o};
                pend_d = lce_data_cmd_v_o && !lce_data_cmd_ready_i;
                sv_d   = {lce_data_cmd_v_o, lce_data_cmd_dst_o, lce_data_cmd_way_o,
                          lce_data_cmd_addr_o, lce_data_cmd_data_o};
                pend_c = lce_cmd_v_o && !lce_cmd_ready_i;
                sv_c   = {lce_cmd_v_o, lce_cmd_dst_o, lce_cmd_way_o, lce_cmd_addr_o, lce_cmd_state_o};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (each returns just after a negedge or posedge+1)
    // ------------------------------------------------------------------
    task automatic send_req(input logic id, input logic [21:0] a, input logic [2:0] way,
                            input logic nx, input logic miss);
        int n;
        @(posedge clk_i);
        #1;
        lce_req_i        = {$urandom, $urandom, $urandom, $urandom};
        lce_req_i[31]    = id;
        lce_req_i[29]    = miss;
        lce_req_i[28:7]  = a;
        lce_req_i[6:4]   = way;
        lce_req_i[32]    = nx;
        lce_req_v_i      = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!lce_req_ready_o && n < 100);
        if (!lce_req_ready_o) fail_now("req_ready_timeout");
        else if (miss) begin
            q_mem.push_back(a);
            q_dcmd.push_back('{dst: id, way: way, addr: a, data: memfn(a)});
            q_cmd.push_back('{dst: id, way: way, addr: a, st: nx ? 2'b01 : 2'b10});
            // A well-formed ack arriving before WAIT_ACK must be ignored.
            lce_resp_i        = '0;
            lce_resp_i[24]    = id;
            lce_resp_i[23:22] = 2'b11;
            lce_resp_i[21:0]  = a;
            lce_resp_v_i      = 1'b1;
        end
        @(posedge clk_i);
        #1;
        lce_req_v_i = 1'b0;
    endtask

    task automatic wait_memcmd();
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(mem_cmd_v_o && mem_cmd_ready_i) && n < 100);
        if (!(mem_cmd_v_o && mem_cmd_ready_i)) fail_now("mem_cmd_timeout");
    endtask

    task automatic serve_mem(input logic [21:0] a, input int dly);
        int n;
        wait_memcmd();
        @(posedge clk_i);
        #1;
        repeat (dly) begin
            @(posedge clk_i);
            #1;
        end
        mem_data_i   = memfn(a);
        mem_data_v_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!mem_data_yumi_o && n < 100);
        if (!mem_data_yumi_o) fail_now("mem_yumi_timeout");
        @(posedge clk_i);
        #1;
        mem_data_v_i = 1'b0;
        mem_data_i   = {16{$urandom}};
    endtask

    task automatic wait_cmd_done(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(lce_cmd_v_o && lce_cmd_ready_i) && n < 100);
        if (!(lce_cmd_v_o && lce_cmd_ready_i)) fail_now("cmd_timeout");
        lce_resp_v_i = 1'b0;
    endtask

    task automatic send_resp(input logic id, input logic [21:0] a, input logic [1:0] ty,
                             input logic expbad);
        int n;
        @(posedge clk_i);
        #1;
        q_resp.push_back(expbad);
        lce_resp_i        = '0;
        lce_resp_i[25]    = 1'($urandom);
        lce_resp_i[24]    = id;
        lce_resp_i[23:22] = ty;
        lce_resp_i[21:0]  = a;
        lce_resp_v_i      = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!lce_resp_yumi_o && n < 100);
        if (!lce_resp_yumi_o) begin
            fail_now("resp_yumi_timeout");
            void'(q_resp.pop_back());
        end
        @(posedge clk_i);
        #1;
        lce_resp_v_i = 1'b0;
    endtask

    task automatic finish_ack(input logic id, input logic [21:0] a, input int nbad);
        int k;
        for (int b = 0; b < nbad; b++) begin
            k = $urandom_range(0, 2);
            if (k == 0)      send_resp(id, a ^ (22'd1 << $urandom_range(0, 21)), 2'b11, 1'b1);
            else if (k == 1) send_resp(~id, a, 2'b11, 1'b1);
            else             send_resp(id, a, 2'($urandom_range(0, 2)), 1'b1);
            chk("busy_after_bad_resp", busy_o, 1'b1);
        end
        send_resp(id, a, 2'b11, 1'b0);
        @(negedge clk_i);
        chk("busy_after_ack", busy_o, 1'b0);
        chk("ready_after_ack", lce_req_ready_o, 1'b1);
    endtask

    task automatic full_txn(input logic id, input logic [21:0] a, input logic [2:0] way,
                            input logic nx, input int dly, input int nbad);
        int n;
        send_req(id, a, way, nx, 1'b1);
        chk("busy_in_txn", busy_o, 1'b1);
        serve_mem(a, dly);
        wait_cmd_done(n);
        finish_ack(id, a, nbad);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        reset_i      = 1'b1;
        lce_req_i    = '0;
        lce_req_v_i  = 1'b0;
        mem_data_i   = '0;
        mem_data_v_i = 1'b0;
        lce_resp_i   = '0;
        lce_resp_v_i = 1'b0;
        #2;
        chk("reset_valids", {lce_req_ready_o, mem_cmd_v_o, mem_data_yumi_o, lce_data_cmd_v_o,
                             lce_cmd_v_o, lce_resp_yumi_o, bad_resp_o, busy_o}, 8'h00);
        chk("reset_latched", {mem_cmd_addr_o, lce_data_cmd_dst_o, lce_data_cmd_way_o,
                              lce_data_cmd_data_o}, '0);
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_reset", lce_req_ready_o, 1'b1);

        // Directed: exclusive miss, all readies high, memory after 2 cycles.
        full_txn(1'b1, 22'h0ABCD, 3'd5, 1'b0, 2, 0);
        // Directed: same request, non-exclusive.
        full_txn(1'b1, 22'h0ABCD, 3'd5, 1'b1, 2, 0);

        // Directed: data command stalled for 5 cycles.
        hold_dready_low = 1'b1;
        send_req(1'b0, 22'h12345, 3'd2, 1'b0, 1'b1);
        serve_mem(22'h12345, 0);
        n = 0;
        while (!lce_data_cmd_v_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("dcmd_v_held", lce_data_cmd_v_o, 1'b1);
            @(negedge clk_i);
        end
        hold_dready_low = 1'b0;
        // Ready rises at the next posedge+1; handshake at the following negedge.
        @(negedge clk_i);
        chk("dcmd_hs_on_ready", {lce_data_cmd_v_o, lce_data_cmd_ready_i}, 2'b11);
        wait_cmd_done(n);
        chk("tag_after_data", n, 1);
        finish_ack(1'b0, 22'h12345, 0);

        // Directed: wrong-address ack, then the correct one.
        send_req(1'b1, 22'h0ABCD, 3'd5, 1'b0, 1'b1);
        serve_mem(22'h0ABCD, 1);
        wait_cmd_done(n);
        send_resp(1'b1, 22'h0ABCE, 2'b11, 1'b1);
        chk("busy_after_addr_mismatch", busy_o, 1'b1);
        finish_ack(1'b1, 22'h0ABCD, 0);

        // Directed: asynchronous reset while waiting for memory.
        send_req(1'b0, 22'h3F00F, 3'd7, 1'b1, 1'b1);
        wait_memcmd();
        @(negedge clk_i);
        #2;
        reset_i      = 1'b1;
        mem_data_v_i = 1'b1;
        lce_resp_v_i = 1'b0;
        #1;
        chk("async_reset_outputs", {lce_req_ready_o, mem_cmd_v_o, mem_data_yumi_o, lce_data_cmd_v_o,
                                    lce_cmd_v_o, lce_resp_yumi_o, bad_resp_o, busy_o}, 8'h00);
        q_mem.delete();
        q_dcmd.delete();
        q_cmd.delete();
        q_resp.delete();
        @(negedge clk_i);
        #2;
        reset_i      = 1'b0;
        mem_data_v_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_abort", {lce_req_ready_o, busy_o}, 2'b10);
        full_txn(1'b1, 22'h00042, 3'd1, 1'b0, 0, 0);

        // Directed: non-miss request is swallowed.
        send_req(1'b1, 22'h11111, 3'd3, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk_i);
            chk("nonmiss_idle", {busy_o, mem_cmd_v_o}, 2'b00);
        end

        // Randomized transactions with random sink back-pressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                send_req(1'($urandom), 22'($urandom), 3'($urandom), 1'($urandom), 1'b0);
                @(negedge clk_i);
                chk("rand_nonmiss_idle", busy_o, 1'b0);
            end
            full_txn(1'($urandom), 22'($urandom), 3'($urandom), 1'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 2));
        end
        rand_ready = 1'b0;

        repeat (3) @(negedge clk_i);
        chk("queues_drained", {32'(q_mem.size()), 32'(q_dcmd.size()), 32'(q_cmd.size()),
                               32'(q_resp.size())}, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
